// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter and dump sequencer
package dmem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_SEND,
        ST_DONE,
        ST_CHK
    } dump_state_e;

    localparam logic [5:0] SIZE_WORD = 6'b000000;
    localparam logic [1:0] BYTE      = 2'b01;
    localparam logic [1:0] HALF      = 2'b10;

endpackage

// File: rtl/dmem_dump_seq.sv
// rtl/dmem_dump_seq.sv - debug dump sequencer: reads a word window and streams it out (DMEM_DUMP_CHECKSUM_EN adds a trailing XOR word)
module dmem_dump_seq
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32,
    parameter int CNT_W       = 11
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cpu_own,
    input  logic                   i_dbg_start,
    input  logic [ADDR_LENGTH-1:0] i_dbg_base,
    input  logic [CNT_W-1:0]       i_dbg_count,
    input  logic [DATA_LENGTH-1:0] i_mem_rdata,
    input  logic                   i_dbg_ready,
    output logic                   o_rd_req,
    output logic [ADDR_LENGTH-1:0] o_rd_addr,
    output logic [DATA_LENGTH-1:0] o_dbg_data,
    output logic                   o_dbg_valid,
    output logic                   o_dbg_busy,
    output logic                   o_dbg_done
);

    dump_state_e            state_q, state_d;
    logic [CNT_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ADDR_LENGTH-1:0] base_q, base_d;
    logic [DATA_LENGTH-1:0] hold_q, hold_d;
`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [DATA_LENGTH-1:0] acc_q, acc_d;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            count_q <= '0;
            base_q  <= '0;
            hold_q  <= '0;
`ifdef DMEM_DUMP_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            base_q  <= base_d;
            hold_q  <= hold_d;
`ifdef DMEM_DUMP_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        base_d  = base_q;
        hold_d  = hold_q;
`ifdef DMEM_DUMP_CHECKSUM_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_dbg_start) begin
                    base_d  = i_dbg_base;
                    count_d = i_dbg_count;
                    idx_d   = '0;
`ifdef DMEM_DUMP_CHECKSUM_EN
                    acc_d   = '0;
                    state_d = (i_dbg_count == '0) ? ST_CHK : ST_RD;
`else
                    state_d = (i_dbg_count == '0) ? ST_DONE : ST_RD;
`endif
                end
            end
            // CPU has fixed priority: the read is simply retried next cycle
            ST_RD: begin
                if (!i_cpu_own) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                hold_d  = i_mem_rdata;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (i_dbg_ready) begin
                    idx_d = idx_q + CNT_W'(1);
`ifdef DMEM_DUMP_CHECKSUM_EN
                    acc_d   = acc_q ^ hold_q;
                    state_d = (idx_q + CNT_W'(1) == count_q) ? ST_CHK : ST_RD;
`else
                    state_d = (idx_q + CNT_W'(1) == count_q) ? ST_DONE : ST_RD;
`endif
                end
            end
`ifdef DMEM_DUMP_CHECKSUM_EN
            ST_CHK: begin
                if (i_dbg_ready) state_d = ST_DONE;
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_rd_req    = (state_q == ST_RD);
    assign o_rd_addr   = base_q + ADDR_LENGTH'(idx_q);
    assign o_dbg_busy  = (state_q != ST_IDLE);
    assign o_dbg_done  = (state_q == ST_DONE);
`ifdef DMEM_DUMP_CHECKSUM_EN
    assign o_dbg_valid = (state_q == ST_SEND) || (state_q == ST_CHK);
    assign o_dbg_data  = (state_q == ST_CHK) ? acc_q : hold_q;
`else
    assign o_dbg_valid = (state_q == ST_SEND);
    assign o_dbg_data  = hold_q;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data_memory port mux: CPU MEM stage first, debug dump sequencer in idle cycles (DMEM_DUMP_CHECKSUM_EN optional)
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_SIZE    = 1024,
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32,
    parameter int CNT_W       = $clog2(MEM_SIZE) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cpu_re,
    input  logic                   i_cpu_we,
    input  logic [ADDR_LENGTH-1:0] i_cpu_addr,
    input  logic [DATA_LENGTH-1:0] i_cpu_wdata,
    input  logic [5:0]             i_cpu_size,
    output logic [DATA_LENGTH-1:0] o_cpu_rdata,
    input  logic                   i_dbg_start,
    input  logic [ADDR_LENGTH-1:0] i_dbg_base,
    input  logic [CNT_W-1:0]       i_dbg_count,
    output logic [DATA_LENGTH-1:0] o_dbg_data,
    output logic                   o_dbg_valid,
    input  logic                   i_dbg_ready,
    output logic                   o_dbg_busy,
    output logic                   o_dbg_done,
    output logic [ADDR_LENGTH-1:0] o_mem_addr,
    output logic                   o_mem_we,
    output logic                   o_mem_re,
    output logic [5:0]             o_mem_size,
    output logic [DATA_LENGTH-1:0] o_mem_wdata,
    input  logic [DATA_LENGTH-1:0] i_mem_rdata
);

    logic                   cpu_own;
    logic                   seq_rd;
    logic [ADDR_LENGTH-1:0] seq_addr;

    assign cpu_own = i_cpu_re | i_cpu_we;

    dmem_dump_seq #(
        .ADDR_LENGTH(ADDR_LENGTH),
        .DATA_LENGTH(DATA_LENGTH),
        .CNT_W      (CNT_W)
    ) u_dump_seq (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_cpu_own  (cpu_own),
        .i_dbg_start(i_dbg_start),
        .i_dbg_base (i_dbg_base),
        .i_dbg_count(i_dbg_count),
        .i_mem_rdata(i_mem_rdata),
        .i_dbg_ready(i_dbg_ready),
        .o_rd_req   (seq_rd),
        .o_rd_addr  (seq_addr),
        .o_dbg_data (o_dbg_data),
        .o_dbg_valid(o_dbg_valid),
        .o_dbg_busy (o_dbg_busy),
        .o_dbg_done (o_dbg_done)
    );

    // CPU inputs pass straight through unless the sequencer has a free cycle to read
    always_comb begin
        o_mem_addr  = i_cpu_addr;
        o_mem_we    = i_cpu_we;
        o_mem_re    = i_cpu_re;
        o_mem_size  = i_cpu_size;
        o_mem_wdata = i_cpu_wdata;
        if (!cpu_own && seq_rd) begin
            o_mem_addr = seq_addr;
            o_mem_we   = 1'b0;
            o_mem_re   = 1'b1;
            o_mem_size = SIZE_WORD;
        end
    end

    assign o_cpu_rdata = i_mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter (honours DMEM_DUMP_CHECKSUM_EN)
module tb_dmem_arbiter;

    localparam int AL = 32;
    localparam int DL = 32;
    localparam int MS = 1024;
    localparam int CW = 11;
`ifdef DMEM_DUMP_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_cpu_re, i_cpu_we;
    logic [AL-1:0] i_cpu_addr;
    logic [DL-1:0] i_cpu_wdata;
    logic [5:0]    i_cpu_size;
    logic [DL-1:0] o_cpu_rdata;
    logic          i_dbg_start;
    logic [AL-1:0] i_dbg_base;
    logic [CW-1:0] i_dbg_count;
    logic [DL-1:0] o_dbg_data;
    logic          o_dbg_valid, i_dbg_ready, o_dbg_busy, o_dbg_done;
    logic [AL-1:0] o_mem_addr;
    logic          o_mem_we, o_mem_re;
    logic [5:0]    o_mem_size;
    logic [DL-1:0] o_mem_wdata;
    logic [DL-1:0] i_mem_rdata;

    always #5 i_clk = ~i_clk;

    dmem_arbiter #(.MEM_SIZE(MS), .ADDR_LENGTH(AL), .DATA_LENGTH(DL), .CNT_W(CW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cpu_re(i_cpu_re), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
        .i_cpu_wdata(i_cpu_wdata), .i_cpu_size(i_cpu_size), .o_cpu_rdata(o_cpu_rdata),
        .i_dbg_start(i_dbg_start), .i_dbg_base(i_dbg_base), .i_dbg_count(i_dbg_count),
        .o_dbg_data(o_dbg_data), .o_dbg_valid(o_dbg_valid), .i_dbg_ready(i_dbg_ready),
        .o_dbg_busy(o_dbg_busy), .o_dbg_done(o_dbg_done),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_re(o_mem_re),
        .o_mem_size(o_mem_size), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
    );

    // 64-word data_memory model with one-cycle registered read
    logic [DL-1:0] mem [0:63];
    logic [DL-1:0] ref_mem [0:63];
    always @(posedge i_clk) begin
        if (o_mem_we) mem[o_mem_addr[5:0]] <= o_mem_wdata;
        if (o_mem_re) i_mem_rdata <= mem[o_mem_addr[5:0]];
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [DL-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] base;
        int          count;
        int          stall;
        int          rlo;
        bit          restart;
        int          exp_ntx;
        int          exp_first;
        int          exp_done;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int ntx = 0, ndone = 0, done_k = -1, first = -1, prev_k = -1, lowcnt = 0;
        bit spacing_bad = 0, stable_bad = 0, busy_bad = 0, finished = 0;
        logic [DL-1:0] held = '0, acc = '0, d;
        logic vv, dn, bz;
        for (int i = 0; i < v.count; i++) begin
            exp_q.push_back(ref_mem[(v.base + i) & 63]);
            acc = acc ^ ref_mem[(v.base + i) & 63];
        end
        if (CK == 1) exp_q.push_back(acc);
        i_dbg_ready = (v.rlo == 0);
        for (int k = 0; k < 300 && !finished; k++) begin
            @(negedge i_clk);
            vv = o_dbg_valid; d = o_dbg_data; dn = o_dbg_done; bz = o_dbg_busy;
            if (k == 0) chk("busy_before_start", {31'd0, bz}, 0);
            if (dn) begin ndone++; if (done_k < 0) done_k = k; end
            if (k > 0 && done_k < 0 && !bz) busy_bad = 1;
            if (done_k >= 0 && k == done_k + 1) begin
                chk("busy_after_done", {31'd0, bz}, 0);
                finished = 1;
            end
            i_dbg_start = (k == 0) || (v.restart && k == 2);
            if (k == 0) begin i_dbg_base = v.base; i_dbg_count = CW'(v.count); end
            if (v.restart && k == 2) begin i_dbg_base = 40; i_dbg_count = 7; end
            i_cpu_we = (k >= 1 && k <= v.stall);
            if (i_cpu_we) ref_mem[20] = 32'h55;
            if (v.rlo > 0 && lowcnt < v.rlo) begin
                i_dbg_ready = 1'b0;
                if (vv) begin
                    if (lowcnt == 0) held = d;
                    else if (d !== held) stable_bad = 1;
                    lowcnt++;
                end else if (lowcnt > 0) stable_bad = 1;
            end else begin
                i_dbg_ready = 1'b1;
            end
            #1;
            if (k >= 1 && k <= v.stall) begin
                chk("cpu_we_pass", {31'd0, o_mem_we}, 1);
                chk("cpu_re_blocked", {31'd0, o_mem_re}, 0);
                chk("cpu_addr_pass", o_mem_addr, 20);
            end
            if (v.count > 0 && k == v.stall + 1) begin
                chk("seq_read_re", {31'd0, o_mem_re}, 1);
                chk("seq_read_addr", o_mem_addr, v.base);
                chk("seq_read_size", {26'd0, o_mem_size}, 0);
            end
            if (vv && i_dbg_ready) begin
                if (exp_q.size() == 0) chk("extra_transfer", 1, 0);
                else chk("dump_data", d, exp_q.pop_front());
                if (first < 0) first = k;
                else if (ntx < v.count && k - prev_k != 3) spacing_bad = 1;
                prev_k = k;
                ntx++;
            end
        end
        i_dbg_start = 1'b0;
        i_cpu_we = 1'b0;
        if (!finished) chk("timeout", 1, 0);
        chk("ntx", ntx, v.exp_ntx);
        chk("first_tx_cycle", first, v.exp_first);
        chk("done_cycle", done_k, v.exp_done);
        chk("done_pulses", ndone, 1);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("busy_during", {31'd0, busy_bad}, 0);
        chk("tx_spacing", {31'd0, spacing_bad}, 0);
        if (v.rlo > 0) chk("backpressure_stable", {31'd0, stable_bad}, 0);
        if (v.stall > 0) chk("cpu_write_landed", mem[20], 32'h55);
        exp_q.delete();
    endtask

    vec_t vecs [7];

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] <= 32'h1000 + i;
            ref_mem[i] = 32'h1000 + i;
        end
        mem[4] <= 32'hA; mem[5] <= 32'hB; mem[6] <= 32'hC;
        ref_mem[4] = 32'hA; ref_mem[5] = 32'hB; ref_mem[6] = 32'hC;
        mem[30] <= 32'hF0; mem[31] <= 32'h0F; mem[32] <= 32'hFF;
        ref_mem[30] = 32'hF0; ref_mem[31] = 32'h0F; ref_mem[32] = 32'hFF;

        //          base count stall rlo rst  ntx    first            done
        vecs[0] = '{4,  3, 0, 0, 0, 3 + CK, 3,               10 + CK};
        vecs[1] = '{4,  3, 0, 5, 0, 3 + CK, 8,               15 + CK};
        vecs[2] = '{8,  2, 1, 0, 0, 2 + CK, 4,               8 + CK};
        vecs[3] = '{0,  0, 0, 0, 0, CK,     (CK == 1) ? 1 : -1, 1 + CK};
        vecs[4] = '{12, 4, 0, 0, 1, 4 + CK, 3,               13 + CK};
        vecs[5] = '{30, 3, 0, 0, 0, 3 + CK, 3,               10 + CK};
        vecs[6] = '{62, 4, 0, 0, 0, 4 + CK, 3,               13 + CK};

        i_rst = 1'b0;
        i_cpu_re = 0; i_cpu_we = 0; i_cpu_addr = 20; i_cpu_wdata = 32'h55; i_cpu_size = 0;
        i_dbg_start = 0; i_dbg_base = 0; i_dbg_count = 0; i_dbg_ready = 1;
        repeat (2) @(negedge i_clk);
        chk("rst_valid", {31'd0, o_dbg_valid}, 0);
        chk("rst_busy", {31'd0, o_dbg_busy}, 0);
        chk("rst_done", {31'd0, o_dbg_done}, 0);
        chk("rst_data", o_dbg_data, 0);
        chk("rst_mem_re", {31'd0, o_mem_re}, 0);
        chk("rst_mem_we", {31'd0, o_mem_we}, 0);
        i_rst = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // abort mid-dump: valid falls with reset, no done pulse follows
        @(negedge i_clk);
        i_dbg_base = 4; i_dbg_count = 3; i_dbg_start = 1; i_dbg_ready = 0;
        @(negedge i_clk);
        i_dbg_start = 0;
        repeat (2) @(negedge i_clk);
        chk("pre_abort_valid", {31'd0, o_dbg_valid}, 1);
        i_rst = 1'b0;
        #1;
        chk("abort_valid", {31'd0, o_dbg_valid}, 0);
        chk("abort_busy", {31'd0, o_dbg_busy}, 0);
        repeat (2) begin
            @(negedge i_clk);
            chk("abort_no_done", {31'd0, o_dbg_done}, 0);
        end
        i_rst = 1'b1;
        i_dbg_ready = 1;
        @(negedge i_clk);
        chk("post_abort_busy", {31'd0, o_dbg_busy}, 0);
        chk("post_abort_done", {31'd0, o_dbg_done}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
